uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter between two byte sources (req0: loopback/echo path, req1: Enigma cipher output).
//  Round-robin arbitration with packet lock, so a multi-byte message is never interleaved with the other source.
//  Sequences the TX core with start/busy and recovers from a stuck core or an abandoned packet via timeouts.
// PARAMETERS
//  START_TIMEOUT  64         max cycles from o_tx_start to i_tx_busy high before abort
//  LOCK_TIMEOUT   1_000_000  max cycles a locked owner may leave valid low between bytes (20 ms at 50 MHz)
// PORTS
//  i_clk_sys       in   1  system clock, all logic on rising edge
//  i_rst           in   1  synchronous, active-high reset
//  i_req0_valid    in   1  req0 byte available; hold with data/last until ready seen
//  i_req0_data     in   8  req0 byte
//  i_req0_last     in   1  byte is last of packet (releases lock)
//  o_req0_ready    out  1  one-cycle accept pulse; transfer = valid & ready
//  i_req1_valid    in   1  as req0
//  i_req1_data     in   8  as req0
//  i_req1_last     in   1  as req0
//  o_req1_ready    out  1  as req0
//  o_tx_data       out  8  byte to TX core, stable from o_tx_start until next accept
//  o_tx_start      out  1  one-cycle start pulse to TX core
//  i_tx_busy       in   1  TX core busy (high for the whole frame)
//  o_grant         out  2  one-hot current owner ({req1,req0}); 00 when idle and unlocked
//  o_err_start_to  out  1  one-cycle pulse: TX core never went busy
//  o_err_lock_to   out  1  one-cycle pulse: locked owner abandoned packet
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lock cleared, priority pointer = req0, both counters 0.
//  FSM states: IDLE -> ACK -> START -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE unlocked: candidate = valid requesters; both valid -> pointer wins; one valid -> it wins; none -> stay.
//  IDLE locked: only owner considered; other requester ignored even if valid.
//  IDLE->ACK on winner: o_grant set (registered); ACK cycle drives o_reqN_ready=1 for exactly one cycle.
//  End of ACK: latch data into o_tx_data; latch last; if last=0 set lock to owner, else mark release pending.
//  START: o_tx_start=1 one cycle. Latency: valid sampled cycle t -> ready at t+1 -> start at t+2.
//  WAIT_BUSY: count cycles; i_tx_busy=1 -> WAIT_DONE; count reaches START_TIMEOUT -> o_err_start_to pulse,
//   clear lock, pointer := other requester, o_grant=00, -> IDLE.
//  WAIT_DONE: wait i_tx_busy=0 (no timeout; frame time bounded by core).
//   -> IDLE; if release pending: clear lock, pointer := other requester, o_grant=00; else keep grant.
//  Lock timeout: counter runs only in IDLE while locked and owner valid=0; reset on owner valid;
//   reaching LOCK_TIMEOUT -> o_err_lock_to pulse, clear lock, pointer := other, o_grant=00.
//  Pointer toggles only on packet end or error, never per byte inside a packet.
//  Requester valid dropping during ACK is a protocol violation; byte is still taken (no rollback).
//  i_tx_busy already high in IDLE: winner still acknowledged; START waits? no - START fires, WAIT_BUSY sees busy.
//  Both errors never pulse in the same cycle (different states). Counters saturate-free: cleared on state entry.
//  Reset mid-frame: next cycle all outputs 0 and lock cleared; TX core is reset by its own logic.
// TESTING
//  1 req0 0xAC last=1, busy model 10 cycles -> ready0 at t+1, start at t+2 with tx_data=0xAC, grant=01, then 00.
//  2 after reset both valid, req0=0x11 req1=0x22 last=1; repeat -> TX order 0x11,0x22,0x11,0x22 (alternation).
//  3 req0 packet 0x01,0x02,0x03(last), req1 0x55 valid throughout -> TX order 01,02,03,55; ready1 low meanwhile.
//  4 i_tx_busy tied 0, START_TIMEOUT=64 -> o_err_start_to pulse 64 cycles after start, IDLE, next byte accepted.
//  5 LOCK_TIMEOUT=50: req0 0x01 last=0 then valid low -> o_err_lock_to after 50 idle cycles, req1 0x55 sent next.
//  6 i_rst asserted during WAIT_DONE -> next cycle ready/start/grant/errs all 0; pointer req0; fresh req0 byte works.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one UART TX core between two byte sources.
// Latency: valid seen -> ready next cycle -> tx start the cycle after; sources hold valid until their one-cycle ready.
module uart_tx_arbiter #(
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT  = 1_000_000
) (
    input  logic       i_clk_sys,
    input  logic       i_rst,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data,
    input  logic       i_req0_last,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data,
    input  logic       i_req1_last,
    output logic       o_req1_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       i_tx_busy,
    output logic [1:0] o_grant,
    output logic       o_err_start_to,
    output logic       o_err_lock_to
);
    localparam int unsigned SW = $clog2(START_TIMEOUT + 1);
    localparam int unsigned LW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACK, S_START, S_WAIT_BUSY, S_WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          lock_q, lock_d;
    logic          rel_q, rel_d;
    logic          ptr_q, ptr_d;
    logic [7:0]    data_q, data_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          err_start, err_lock;

    // Owner is only meaningful while grant_q is non-zero (ACK onwards, or locked IDLE).
    logic       owner;
    logic       own_vld, own_last;
    logic [7:0] own_data;

    assign owner    = grant_q[1];
    assign own_vld  = owner ? i_req1_valid : i_req0_valid;
    assign own_last = owner ? i_req1_last  : i_req0_last;
    assign own_data = owner ? i_req1_data  : i_req0_data;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        lock_d    = lock_q;
        rel_d     = rel_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        scnt_d    = '0;
        lcnt_d    = '0;
        err_start = 1'b0;
        err_lock  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lock_q) begin
                    if (own_vld) begin
                        state_d = S_ACK;
                    end else if (lcnt_q == LW'(LOCK_TIMEOUT - 1)) begin
                        err_lock = 1'b1;
                        lock_d   = 1'b0;
                        ptr_d    = ~owner;
                        grant_d  = 2'b00;
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end else if (i_req0_valid && (!i_req1_valid || !ptr_q)) begin
                    grant_d = 2'b01;
                    state_d = S_ACK;
                end else if (i_req1_valid) begin
                    grant_d = 2'b10;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                // Byte is taken even if the source dropped valid this cycle.
                data_d = own_data;
                if (own_last) rel_d = 1'b1;
                else          lock_d = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (scnt_q == SW'(START_TIMEOUT - 1)) begin
                    err_start = 1'b1;
                    lock_d    = 1'b0;
                    rel_d     = 1'b0;
                    ptr_d     = ~owner;
                    grant_d   = 2'b00;
                    state_d   = S_IDLE;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = S_IDLE;
                    if (rel_q) begin
                        lock_d  = 1'b0;
                        rel_d   = 1'b0;
                        ptr_d   = ~owner;
                        grant_d = 2'b00;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            lock_q  <= 1'b0;
            rel_q   <= 1'b0;
            ptr_q   <= 1'b0;
            data_q  <= 8'h00;
            scnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
            rel_q   <= rel_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            scnt_q  <= scnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign o_req0_ready   = (state_q == S_ACK) && grant_q[0];
    assign o_req1_ready   = (state_q == S_ACK) && grant_q[1];
    assign o_tx_start     = (state_q == S_START);
    assign o_tx_data      = data_q;
    assign o_grant        = grant_q;
    assign o_err_start_to = err_start;
    assign o_err_lock_to  = err_lock;
endmodule
